mem_stage_v2: RTL and testbench
===============================

// Module: mem_stage_v2
// PURPOSE
//  Parametrised MEM pipeline stage. Registers the EX->MEM payload and handles loads from a variable-latency
//  data memory (rvalid handshake); raises a stall request while a load response is outstanding.
//  Aligns and sign/zero-extends byte/half/word loads. Drives the MEM->WB register and the MEM->ID forwarding port.
// PARAMETERS
//  XLEN        32   datapath width; 32 or 64 (64 adds LD_W/LD_WU/LD_D)
//  RAW         5    register-file address width
//  PC_W        32   PC width
//  TIMEOUT     255  max wait cycles for rvalid before err_timeout; 0 disables the check
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset, synchronous, active-high
//  stall_mem    in   1      hold this stage's input register (stall bit of MEM)
//  stall_wb     in   1      WB held
//  flush        in   1      kill the instruction in MEM
//  ex_valid     in   1      EX payload valid
//  ex_pc        in   PC_W   instruction PC
//  ex_is_load   in   1      instruction is a load
//  ex_ld_type   in   3      load type, encoded per mem_pkg
//  ex_addr_lo   in   3      low byte-address bits (only [1:0] used when XLEN=32)
//  ex_rf_we     in   1      register write enable
//  ex_rf_waddr  in   RAW    destination register
//  ex_result    in   XLEN   ALU result or store passthrough
//  dmem_rvalid  in   1      load data valid this cycle
//  dmem_rdata   in   XLEN   raw aligned memory word
//  mem_stallreq out  1      load waiting for rvalid
//  fwd_we       out  1      forwarding valid (rf_we and result available)
//  fwd_pending  out  1      load in MEM, data not yet available; ID must stall on match
//  fwd_waddr    out  RAW    forwarding destination
//  fwd_wdata    out  XLEN   forwarding data
//  wb_valid     out  1      WB payload valid
//  wb_pc        out  PC_W   PC to WB
//  wb_rf_we     out  1      register write enable to WB
//  wb_rf_waddr  out  RAW    destination register to WB
//  wb_wdata     out  XLEN   write data to WB
//  err_timeout  out  1      sticky; set when TIMEOUT is exceeded
// BEHAVIOUR
//  - Input register update, in priority order:
//      rst -> all zero
//      flush -> zero (bubble)
//      stall_mem & !stall_wb -> zero (bubble)
//      !stall_mem -> load ex_*
//      otherwise -> hold
//  - wb_* outputs are combinational from the registered payload plus the load path.
//    wb_valid = r_valid & !mem_stallreq. All outputs are 0 out of reset.
//  - FSM, states IDLE / WAIT / HELD. Reset state is IDLE.
//      IDLE: if a valid load is present and !dmem_rvalid -> WAIT.
//            if rvalid arrives in the first cycle, no stall is raised (1-cycle memory = zero bubbles).
//      WAIT: mem_stallreq=1 and wait counter increments. On rvalid, stallreq drops in that same cycle
//            (combinational) and data is used directly.
//            If stall_mem is still asserted (downstream hold): capture rdata into hold_q -> HELD.
//            Otherwise -> IDLE.
//      HELD: data comes from hold_q; stallreq=0; -> IDLE when the input register advances or is flushed.
//      IDLE with rvalid and stall_mem: also capture -> HELD.
//  - flush or rst in any state -> IDLE, counter cleared, hold_q discarded.
//    A late rvalid belonging to the flushed load is ignored: an rvalid with no load in WAIT/IDLE is dropped.
//  - Counter is 8 bits and saturates. When count == TIMEOUT, err_timeout is set (sticky until rst).
//    The FSM keeps waiting.
//  - Load align:
//      shift = addr_lo * 8
//      LB/LH/LW: sign-extend from bit 7/15/31
//      LBU/LHU/LWU: zero-extend
//      LD (XLEN=64 only): full word
//    Misaligned halfword/word/doubleword is undefined here; EX traps it.
//  - wdata = is_load ? aligned_load : ex_result. Non-load instructions never stall.
//  - Forwarding:
//      fwd_we = r_rf_we & !(is_load & data not yet available)
//      fwd_pending = r_valid & is_load & r_rf_we & data not yet available
// STRUCTURE
//  - mem_pkg: LD_B/LD_BU/LD_H/LD_HU/LD_W/LD_WU/LD_D encodings (3'd0..6); FSM state encodings.
//  - Sub-module load_align (XLEN param; combinational inputs rdata, ld_type, addr_lo -> out).
//  - Top module holds the input register, FSM, counter, hold_q and output muxes.
// TESTING
//  1. ALU op, ex_result=32'h1234, rf_we, waddr=5, no stalls
//     -> next cycle wb_wdata=32'h1234, fwd_we=1, mem_stallreq=0.
//  2. LB, addr_lo=2, rvalid in first cycle, rdata=32'h00_80_00_00
//     -> wb_wdata=32'hFFFFFF80, no stall. Repeat as LBU -> 32'h00000080.
//  3. LH, rvalid 3 cycles late
//     -> mem_stallreq=1 and fwd_pending=1 for exactly 3 cycles; on the rvalid cycle stallreq=0 and wb_wdata is correct.
//  4. rvalid arrives while stall_mem=1 and stall_wb=1
//     -> HELD; when rdata changes afterwards, wb_wdata still equals the captured value; -> IDLE on release.
//  5. flush during WAIT, then a stray rvalid
//     -> IDLE, wb_valid=0, no capture; the next ALU instruction passes through unaffected.
//  6. TIMEOUT=4, no rvalid -> err_timeout rises on the 4th wait cycle and stays 1 until rst.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Load-type and MEM-stage FSM encodings shared by the MEM stage.
// Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_BU = 3'd1,
    LD_H  = 3'd2,
    LD_HU = 3'd3,
    LD_W  = 3'd4,
    LD_WU = 3'd5,
    LD_D  = 3'd6
  } ld_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HELD = 2'd2
  } mem_state_e;

  localparam logic [7:0] C_CNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == C_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Purpose  : Shifts the raw memory word by the byte offset and sign/zero
//            extends it according to the load type.
// Revision : 1.0  initial release
// ============================================================================
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      ld_type,
  input  logic [2:0]      addr_lo,
  output logic [XLEN-1:0] out
);

  logic [2:0]      w_addr;
  logic [5:0]      w_shamt;
  logic [XLEN-1:0] w_sh;

  // Bit 2 of the offset only exists for a 64-bit datapath.
  assign w_addr  = (XLEN == 64) ? addr_lo : {1'b0, addr_lo[1:0]};
  assign w_shamt = {w_addr, 3'b000};
  assign w_sh    = rdata >> w_shamt;

  always_comb begin
    out = w_sh;
    case (ld_type)
      LD_B:    out = XLEN'($signed(w_sh[7:0]));
      LD_BU:   out = XLEN'(w_sh[7:0]);
      LD_H:    out = XLEN'($signed(w_sh[15:0]));
      LD_HU:   out = XLEN'(w_sh[15:0]);
      LD_W:    out = XLEN'($signed(w_sh[31:0]));
      LD_WU:   out = XLEN'(w_sh[31:0]);
      default: out = w_sh;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_v2.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_v2
// Purpose  : MEM pipeline stage with variable-latency load handshake, load
//            alignment, WB payload and ID forwarding port.
// Revision : 1.0  initial release
// ============================================================================
module mem_stage_v2
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RAW     = 5,
  parameter int PC_W    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_mem,
  input  logic            stall_wb,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_is_load,
  input  logic [2:0]      ex_ld_type,
  input  logic [2:0]      ex_addr_lo,
  input  logic            ex_rf_we,
  input  logic [RAW-1:0]  ex_rf_waddr,
  input  logic [XLEN-1:0] ex_result,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stallreq,
  output logic            fwd_we,
  output logic            fwd_pending,
  output logic [RAW-1:0]  fwd_waddr,
  output logic [XLEN-1:0] fwd_wdata,
  output logic            wb_valid,
  output logic [PC_W-1:0] wb_pc,
  output logic            wb_rf_we,
  output logic [RAW-1:0]  wb_rf_waddr,
  output logic [XLEN-1:0] wb_wdata,
  output logic            err_timeout
);

  logic            r_valid;
  logic [PC_W-1:0] r_pc;
  logic            r_is_load;
  logic [2:0]      r_ld_type;
  logic [2:0]      r_addr_lo;
  logic            r_rf_we;
  logic [RAW-1:0]  r_rf_waddr;
  logic [XLEN-1:0] r_result;

  mem_state_e      r_state;
  mem_state_e      w_state_nxt;
  logic [7:0]      r_cnt;
  logic [XLEN-1:0] r_hold;
  logic            r_err;

  logic            w_load_act;
  logic            w_reg_hold;
  logic            w_avail;
  logic            w_capture;
  logic            w_tmo;
  logic [XLEN-1:0] w_raw;
  logic [XLEN-1:0] w_aligned;

  // Input register: bubble on flush or when MEM stalls but WB drains.
  always_ff @(posedge clk) begin
    if (rst || flush || (stall_mem && !stall_wb)) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_is_load  <= 1'b0;
      r_ld_type  <= 3'd0;
      r_addr_lo  <= 3'd0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_result   <= '0;
    end else if (!stall_mem) begin
      r_valid    <= ex_valid;
      r_pc       <= ex_pc;
      r_is_load  <= ex_is_load;
      r_ld_type  <= ex_ld_type;
      r_addr_lo  <= ex_addr_lo;
      r_rf_we    <= ex_rf_we;
      r_rf_waddr <= ex_rf_waddr;
      r_result   <= ex_result;
    end
  end

  assign w_load_act = r_valid & r_is_load;
  assign w_reg_hold = stall_mem & stall_wb & ~flush;
  assign w_avail    = (r_state == ST_HELD) | dmem_rvalid;
  assign w_raw      = (r_state == ST_HELD) ? r_hold : dmem_rdata;
  assign w_tmo      = (TIMEOUT != 0) && (r_state == ST_WAIT) && (r_cnt == 8'(TIMEOUT));

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_load_act) begin
          if (!dmem_rvalid) begin
            w_state_nxt = ST_WAIT;
          end else if (w_reg_hold) begin
            w_state_nxt = ST_HELD;
            w_capture   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // A response with no load left in the register is stale and dropped.
        if (!w_load_act) begin
          w_state_nxt = ST_IDLE;
        end else if (dmem_rvalid) begin
          if (w_reg_hold) begin
            w_state_nxt = ST_HELD;
            w_capture   = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_HELD: begin
        if (!w_reg_hold) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_capture   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_cnt  <= 8'd0;
      r_hold <= '0;
    end else begin
      if (w_state_nxt == ST_WAIT) r_cnt <= (r_state == ST_WAIT) ? sat_inc8(r_cnt) : 8'd1;
      else                        r_cnt <= 8'd0;
      if (w_capture) r_hold <= dmem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        r_err <= 1'b0;
    else if (w_tmo) r_err <= 1'b1;
  end

  load_align #(
    .XLEN(XLEN)
  ) u_align (
    .rdata  (w_raw),
    .ld_type(r_ld_type),
    .addr_lo(r_addr_lo),
    .out    (w_aligned)
  );

  assign mem_stallreq = w_load_act & ~w_avail;
  assign wb_valid     = r_valid & ~mem_stallreq;
  assign wb_pc        = r_pc;
  assign wb_rf_we     = r_rf_we & wb_valid;
  assign wb_rf_waddr  = r_rf_waddr;
  assign wb_wdata     = r_is_load ? w_aligned : r_result;
  assign fwd_we       = r_rf_we & ~(r_is_load & ~w_avail);
  assign fwd_pending  = r_valid & r_is_load & r_rf_we & ~w_avail;
  assign fwd_waddr    = r_rf_waddr;
  assign fwd_wdata    = wb_wdata;
  assign err_timeout  = r_err | w_tmo;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_v2
// Purpose  : Self-checking bench for mem_stage_v2 (directed + random loads).
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage_v2;

  logic        clk = 1'b0;
  logic        rst, stall_mem, stall_wb, flush;
  logic        ex_valid, ex_is_load, ex_rf_we, dmem_rvalid;
  logic [31:0] ex_pc, ex_result, dmem_rdata;
  logic [2:0]  ex_ld_type, ex_addr_lo;
  logic [4:0]  ex_rf_waddr;
  logic        mem_stallreq, fwd_we, fwd_pending, wb_valid, wb_rf_we, err_timeout;
  logic [4:0]  fwd_waddr, wb_rf_waddr;
  logic [31:0] fwd_wdata, wb_pc, wb_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_stage_v2 #(.XLEN(32), .RAW(5), .PC_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_load(ex_is_load), .ex_ld_type(ex_ld_type),
    .ex_addr_lo(ex_addr_lo), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_result(ex_result), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_stallreq(mem_stallreq), .fwd_we(fwd_we), .fwd_pending(fwd_pending),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr), .wb_wdata(wb_wdata),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load result: select the addressed field, then extend.
  function automatic logic [31:0] exp_load(input logic [31:0] d, input logic [2:0] t,
                                           input logic [1:0] a);
    logic [31:0] v, m;
    int          w;
    bit          sgn;
    case (t)
      3'd0:    begin w = 8;  sgn = 1'b1; end
      3'd1:    begin w = 8;  sgn = 1'b0; end
      3'd2:    begin w = 16; sgn = 1'b1; end
      3'd3:    begin w = 16; sgn = 1'b0; end
      default: begin w = 32; sgn = 1'b0; end
    endcase
    v = d >> (8 * a);
    if (w < 32) begin
      m = (32'd1 << w) - 32'd1;
      v = v & m;
      if (sgn && v[w-1]) v = v | ~m;
    end
    return v;
  endfunction

  task automatic bubble();
    ex_valid = 0; ex_pc = 0; ex_is_load = 0; ex_ld_type = 0; ex_addr_lo = 0;
    ex_rf_we = 0; ex_rf_waddr = 0; ex_result = 0;
  endtask

  task automatic issue(input bit ld, input logic [2:0] t, input logic [1:0] a, input logic [31:0] res,
                       input logic [4:0] wa, input logic [31:0] pc, input bit we);
    ex_valid = 1; ex_pc = pc; ex_is_load = ld; ex_ld_type = t; ex_addr_lo = {1'b0, a};
    ex_rf_we = we; ex_rf_waddr = wa; ex_result = res;
    stall_mem = 0; stall_wb = 0; flush = 0; dmem_rvalid = 0; dmem_rdata = $urandom;
    @(negedge clk);
    chk("issue_wb_valid", 64'(wb_valid), 64'd0);
    tick();
    bubble();
  endtask

  task automatic run_txn(input bit ld, input logic [2:0] t, input logic [1:0] a, input logic [31:0] d,
                         input int lat, input logic [31:0] res, input logic [4:0] wa,
                         input logic [31:0] pc, input bit we);
    logic [31:0] exp;
    exp = ld ? exp_load(d, t, a) : res;
    issue(ld, t, a, res, wa, pc, we);
    if (ld) begin
      for (int k = 0; k < lat; k++) begin
        stall_mem = 1; stall_wb = 1; dmem_rvalid = 0; dmem_rdata = $urandom;
        @(negedge clk);
        chk("wait_stallreq", 64'(mem_stallreq), 64'd1);
        chk("wait_pending", 64'(fwd_pending), 64'(we));
        chk("wait_wb_valid", 64'(wb_valid), 64'd0);
        chk("wait_fwd_we", 64'(fwd_we), 64'd0);
        tick();
      end
    end
    stall_mem = 0; stall_wb = 0; dmem_rvalid = ld; dmem_rdata = d;
    @(negedge clk);
    chk("done_stallreq", 64'(mem_stallreq), 64'd0);
    chk("done_wb_valid", 64'(wb_valid), 64'd1);
    chk("done_wdata", 64'(wb_wdata), 64'(exp));
    chk("done_pc", 64'(wb_pc), 64'(pc));
    chk("done_rf_we", 64'(wb_rf_we), 64'(we));
    chk("done_waddr", 64'(wb_rf_waddr), 64'(wa));
    chk("done_fwd_we", 64'(fwd_we), 64'(we));
    chk("done_fwd_pending", 64'(fwd_pending), 64'd0);
    chk("done_fwd_wdata", 64'(fwd_wdata), 64'(exp));
    chk("done_fwd_waddr", 64'(fwd_waddr), 64'(wa));
    chk("done_err", 64'(err_timeout), 64'd0);
    tick();
    dmem_rvalid = 0;
  endtask

  initial begin
    logic [2:0] t;
    logic [1:0] a;
    rst = 1; stall_mem = 0; stall_wb = 0; flush = 0; dmem_rvalid = 0; dmem_rdata = 0;
    bubble();
    tick(); tick();
    @(negedge clk);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_stallreq", 64'(mem_stallreq), 64'd0);
    chk("rst_fwd_we", 64'(fwd_we), 64'd0);
    chk("rst_pending", 64'(fwd_pending), 64'd0);
    chk("rst_wdata", 64'(wb_wdata), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    tick();
    rst = 0;

    // ALU op, then single-cycle loads with sign and zero extension
    run_txn(0, 3'd0, 2'd0, 32'h0, 0, 32'h1234, 5'd5, 32'h100, 1);
    run_txn(1, 3'd0, 2'd2, 32'h0080_0000, 0, 32'h0, 5'd6, 32'h104, 1);
    run_txn(1, 3'd1, 2'd2, 32'h0080_0000, 0, 32'h0, 5'd6, 32'h108, 1);
    chk("lb_model", 64'(exp_load(32'h0080_0000, 3'd0, 2'd2)), 64'hFFFF_FF80);
    // LH, response three cycles late
    run_txn(1, 3'd2, 2'd2, 32'hC0DE_0000, 3, 32'h0, 5'd7, 32'h10C, 1);

    // Response lands while downstream is held: value must be captured
    issue(1, 3'd4, 2'd0, 32'h0, 5'd8, 32'h110, 1);
    stall_mem = 1; stall_wb = 1; dmem_rvalid = 0;
    @(negedge clk);
    chk("held_pre_stall", 64'(mem_stallreq), 64'd1);
    tick();
    dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("held_rv_stallreq", 64'(mem_stallreq), 64'd0);
    chk("held_rv_wdata", 64'(wb_wdata), 64'hDEAD_BEEF);
    tick();
    dmem_rvalid = 0; dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("held_keep_wdata", 64'(wb_wdata), 64'hDEAD_BEEF);
    chk("held_keep_stallreq", 64'(mem_stallreq), 64'd0);
    chk("held_keep_valid", 64'(wb_valid), 64'd1);
    tick();
    stall_mem = 0; stall_wb = 0;
    @(negedge clk);
    chk("held_rel_wdata", 64'(wb_wdata), 64'hDEAD_BEEF);
    tick();
    @(negedge clk);
    chk("held_after_valid", 64'(wb_valid), 64'd0);
    run_txn(1, 3'd4, 2'd0, 32'hA5A5_0F0F, 0, 32'h0, 5'd9, 32'h114, 1);

    // Flush while waiting, then a stray response
    issue(1, 3'd4, 2'd0, 32'h0, 5'd10, 32'h118, 1);
    stall_mem = 1; stall_wb = 1;
    tick();
    flush = 1;
    @(negedge clk);
    chk("flush_stallreq", 64'(mem_stallreq), 64'd1);
    tick();
    flush = 0; stall_mem = 0; stall_wb = 0; dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("stray_wb_valid", 64'(wb_valid), 64'd0);
    chk("stray_stallreq", 64'(mem_stallreq), 64'd0);
    chk("stray_fwd_we", 64'(fwd_we), 64'd0);
    chk("stray_pending", 64'(fwd_pending), 64'd0);
    tick();
    dmem_rvalid = 0;
    run_txn(0, 3'd0, 2'd0, 32'h0, 0, 32'h0BAD_F00D, 5'd11, 32'h11C, 1);

    // Randomized mix of ALU ops and loads with latency 0..3
    for (int i = 0; i < 40; i++) begin
      t = 3'($urandom_range(0, 5));
      case (t)
        3'd0, 3'd1: a = 2'($urandom_range(0, 3));
        3'd2, 3'd3: a = 2'($urandom_range(0, 1) * 2);
        default:    a = 2'd0;
      endcase
      run_txn(1'($urandom_range(0, 1)), t, a, $urandom, $urandom_range(0, 3), $urandom,
              5'($urandom), $urandom, 1'($urandom_range(0, 1)));
    end

    // Timeout: no response ever arrives
    issue(1, 3'd4, 2'd0, 32'h0, 5'd12, 32'h200, 1);
    for (int k = 0; k < 5; k++) begin
      stall_mem = 1; stall_wb = 1; dmem_rvalid = 0;
      @(negedge clk);
      chk("tmo_err", 64'(err_timeout), (k == 4) ? 64'd1 : 64'd0);
      tick();
    end
    flush = 1;
    tick();
    flush = 0; stall_mem = 0; stall_wb = 0;
    tick(); tick();
    @(negedge clk);
    chk("tmo_sticky", 64'(err_timeout), 64'd1);
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("tmo_cleared", 64'(err_timeout), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
